// File: rtl/jtag_host_master.sv
// jtag_host_master
// On-chip JTAG initiator. Takes one command at a time over a valid/ready
// interface (TAP reset, IR shift, DR shift, idle clocks), generates
// TCK/TMS/TDI for a target TAP, and returns the TDO bits captured during the
// shift.
//
// Ports:
//   sys_root_clk   system clock, rising edge only
//   sys_root_rstn  synchronous active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_type       00 TAP reset, 01 IR shift, 10 DR shift, 11 idle clocks
//   cmd_len        shift length in bits, or TCK count for idle
//   cmd_data       TDI data, LSB shifted first
//   rsp_valid      one-cycle completion pulse
//   rsp_data       captured TDO, bit i sampled during shift bit i
//   jtag_tck/jtag_tms/jtag_tdi  JTAG outputs
//   jtag_tdo       JTAG input from target
module jtag_host_master #(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 64
) (
    input  logic               sys_root_clk,
    input  logic               sys_root_rstn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_type,
    input  logic [6:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               jtag_tck,
    output logic               jtag_tms,
    output logic               jtag_tdi,
    input  logic               jtag_tdo
);

    localparam int         IDX_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [6:0] LEN_MAX  = 7'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE,
        TLR,
        PRE,
        SHIFT,
        POST,
        WAIT,
        DONE
    } state_t;

    state_t             state;
    logic [7:0]         div_cnt;
    logic [6:0]         len;      // effective length of the active command
    logic [6:0]         cnt;      // TCK cycle index within the current state
    logic               is_ir;
    logic [MAX_LEN-1:0] data_sr;  // remaining TDI bits, next bit at [0]
    logic [MAX_LEN-1:0] cap;      // TDO bits captured so far

    logic       accept;
    logic       active;
    logic       div_tick;
    logic       rise;
    logic       fall;
    logic       load_bit;
    logic [6:0] shift_len;
    logic [6:0] pre_last;
    logic [6:0] len_last;

    assign accept   = cmd_valid && cmd_ready;
    assign div_tick = (div_cnt == DIV_LAST);
    assign pre_last = is_ir ? 7'd3 : 7'd2;
    assign len_last = len - 7'd1;

    // TCK only runs while a command with at least one TCK cycle is in flight.
    assign active = (state == TLR) || (state == PRE) || (state == SHIFT) ||
                    (state == POST) || ((state == WAIT) && (len != 7'd0));
    assign rise   = active && div_tick && !jtag_tck;
    assign fall   = active && div_tick && jtag_tck;

    // A falling edge that starts a shift bit presents the next TDI bit.
    assign load_bit = fall && (((state == PRE) && (cnt == pre_last)) ||
                               ((state == SHIFT) && (cnt != len_last)));

    // Shift lengths: 0 behaves as 1, anything past MAX_LEN is clamped.
    always_comb begin
        shift_len = cmd_len;
        if (cmd_len == 7'd0) begin
            shift_len = 7'd1;
        end else if (cmd_len > LEN_MAX) begin
            shift_len = LEN_MAX;
        end
    end

    // Data path: TDI shift register and TDO capture, no reset needed.
    always_ff @(posedge sys_root_clk) begin
        if (accept) begin
            data_sr <= cmd_data;
            cap     <= '0;
        end else begin
            if (rise && (state == SHIFT)) begin
                cap[cnt[IDX_W-1:0]] <= jtag_tdo;
            end
            if (load_bit) begin
                data_sr <= data_sr >> 1;
            end
        end
    end

    // Control FSM with registered JTAG and handshake outputs.
    always_ff @(posedge sys_root_clk) begin
        if (!sys_root_rstn) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            jtag_tck  <= 1'b0;
            jtag_tms  <= 1'b1;
            jtag_tdi  <= 1'b0;
            div_cnt   <= 8'd0;
            cnt       <= 7'd0;
            len       <= 7'd0;
            is_ir     <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;

            if (active) begin
                div_cnt <= div_tick ? 8'd0 : div_cnt + 8'd1;
                if (div_tick) begin
                    jtag_tck <= ~jtag_tck;
                end
            end

            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        div_cnt   <= 8'd0;
                        cnt       <= 7'd0;
                        jtag_tdi  <= 1'b0;
                        is_ir     <= (cmd_type == 2'b01);
                        case (cmd_type)
                            2'b00: begin
                                state    <= TLR;
                                jtag_tms <= 1'b1;
                                len      <= 7'd6;
                            end
                            2'b11: begin
                                state    <= WAIT;
                                jtag_tms <= 1'b0;
                                len      <= cmd_len;
                            end
                            default: begin
                                state    <= PRE;
                                jtag_tms <= 1'b1;
                                len      <= shift_len;
                            end
                        endcase
                    end
                end

                TLR: begin
                    if (fall) begin
                        if (cnt == 7'd5) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                        end else begin
                            cnt      <= cnt + 7'd1;
                            // Five ones then a zero lands in Run-Test/Idle.
                            jtag_tms <= (cnt != 7'd4);
                        end
                    end
                end

                PRE: begin
                    if (fall) begin
                        if (cnt == pre_last) begin
                            state    <= SHIFT;
                            cnt      <= 7'd0;
                            jtag_tms <= (len == 7'd1);
                            jtag_tdi <= data_sr[0];
                        end else begin
                            cnt      <= cnt + 7'd1;
                            // IR path needs a second 1 to reach Select-IR.
                            jtag_tms <= is_ir && (cnt == 7'd0);
                        end
                    end
                end

                SHIFT: begin
                    if (fall) begin
                        if (cnt == len_last) begin
                            state    <= POST;
                            cnt      <= 7'd0;
                            jtag_tms <= 1'b1;
                            jtag_tdi <= 1'b0;
                        end else begin
                            cnt      <= cnt + 7'd1;
                            // Last bit carries TMS=1 to leave via Exit1.
                            jtag_tms <= ((cnt + 7'd1) == len_last);
                            jtag_tdi <= data_sr[0];
                        end
                    end
                end

                POST: begin
                    if (fall) begin
                        if (cnt == 7'd0) begin
                            cnt      <= 7'd1;
                            jtag_tms <= 1'b0;
                        end else begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_data  <= cap;
                        end
                    end
                end

                WAIT: begin
                    if (len == 7'd0) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_data  <= '0;
                    end else if (fall) begin
                        if (cnt == len_last) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                        end else begin
                            cnt <= cnt + 7'd1;
                        end
                    end
                end

                DONE: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_host_master.sv
// Testbench for jtag_host_master (CLK_DIV=2, MAX_LEN=64). Directed commands
// from the test plan followed by random commands, each compared against a
// sequence-level model of the expected TMS/TDI/TCK/response behaviour.
module tb_jtag_host_master;

    localparam int CLK_DIV = 2;
    localparam int MAX_LEN = 64;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_type = 2'b00;
    logic [6:0]         cmd_len = 7'd0;
    logic [MAX_LEN-1:0] cmd_data = '0;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;
    logic               jtag_tck;
    logic               jtag_tms;
    logic               jtag_tdi;
    wire logic          jtag_tdo;

    int   tdo_mode = 0;   // 0 loopback, 1 constant tdo_r, 2 random per TCK
    logic tdo_r = 1'b0;
    assign jtag_tdo = (tdo_mode == 0) ? jtag_tdi : tdo_r;

    jtag_host_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
        .sys_root_clk (clk),
        .sys_root_rstn(rstn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_type     (cmd_type),
        .cmd_len      (cmd_len),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .jtag_tck     (jtag_tck),
        .jtag_tms     (jtag_tms),
        .jtag_tdi     (jtag_tdi),
        .jtag_tdo     (jtag_tdo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: records TMS/TDI/TDO at each TCK rising edge.
    logic [127:0] tms_v = '0;
    logic [127:0] tdi_v = '0;
    logic [127:0] tdo_v = '0;
    int           n_rise = 0;
    int           n_rsp = 0;
    logic         prev_tck = 1'b0;

    always @(posedge clk) begin
        #1;
        if (jtag_tck === 1'b1 && prev_tck === 1'b0) begin
            if (n_rise < 128) begin
                tms_v[n_rise] = jtag_tms;
                tdi_v[n_rise] = jtag_tdi;
                tdo_v[n_rise] = jtag_tdo;
            end
            n_rise++;
        end
        if (jtag_tck === 1'b0 && prev_tck === 1'b1 && tdo_mode == 2)
            tdo_r = 1'($urandom_range(0, 1));
        prev_tck = jtag_tck;
        if (rsp_valid === 1'b1) n_rsp++;
    end

    int n_total = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Expected line activity built straight from the command's TMS recipe.
    function automatic void model(input logic [1:0] t, input logic [6:0] l,
                                  input logic [63:0] d,
                                  output logic [127:0] tms_e, output logic [127:0] tdi_e,
                                  output int n, output int pre, output int nb);
        tms_e = '0;
        tdi_e = '0;
        n = 0;
        pre = 0;
        nb = 0;
        if (t == 2'b00) begin
            for (int i = 0; i < 5; i++) tms_e[i] = 1'b1;
            n = 6;
        end else if (t == 2'b11) begin
            n = int'(l);
        end else begin
            nb = (l == 0) ? 1 : ((int'(l) > MAX_LEN) ? MAX_LEN : int'(l));
            pre = (t == 2'b01) ? 4 : 3;
            tms_e[0] = 1'b1;
            if (t == 2'b01) tms_e[1] = 1'b1;
            for (int i = 0; i < nb; i++) tdi_e[pre + i] = d[i];
            tms_e[pre + nb - 1] = 1'b1;
            tms_e[pre + nb] = 1'b1;
            n = pre + nb + 2;
        end
    endfunction

    int acc_cyc;

    task automatic issue(input logic [1:0] t, input logic [6:0] l, input logic [63:0] d,
                         input string tag);
        int k;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 50) begin step(); k++; end
        chk({tag, "_ready_idle"}, 128'(cmd_ready), 128'(1));
        tms_v = '0; tdi_v = '0; tdo_v = '0; n_rise = 0; n_rsp = 0;
        cmd_type = t; cmd_len = l; cmd_data = d; cmd_valid = 1'b1;
        step();
        acc_cyc = cyc;
    endtask

    task automatic do_cmd(input logic [1:0] t, input logic [6:0] l, input logic [63:0] d,
                          input bit hold, input string tag);
        int k, rsp_cyc, e_n, e_pre, e_nb, lat;
        bit busy_rdy;
        logic [127:0] e_tms, e_tdi;
        logic [63:0] e_rsp;
        issue(t, l, d, tag);
        if (hold) begin
            // Keep requesting a different command while busy.
            cmd_type = ~t; cmd_data = ~d;
        end else begin
            cmd_valid = 1'b0;
        end
        busy_rdy = 1'b0;
        k = 0;
        while (rsp_valid !== 1'b1 && k < 3000) begin
            if (cmd_ready !== 1'b0) busy_rdy = 1'b1;
            step();
            k++;
        end
        rsp_cyc = cyc;
        cmd_valid = 1'b0;
        chk({tag, "_rsp_seen"}, 128'(rsp_valid), 128'(1));
        chk({tag, "_busy_ready_low"}, 128'(busy_rdy), 128'(0));
        model(t, l, d, e_tms, e_tdi, e_n, e_pre, e_nb);
        e_rsp = '0;
        for (int i = 0; i < e_nb; i++) e_rsp[i] = tdo_v[e_pre + i];
        lat = (e_n == 0) ? 1 : 2 * CLK_DIV * e_n;
        chk({tag, "_tck_count"}, 128'(n_rise), 128'(e_n));
        chk({tag, "_tms_seq"}, tms_v, e_tms);
        chk({tag, "_tdi_seq"}, tdi_v, e_tdi);
        chk({tag, "_rsp_data"}, 128'(rsp_data), 128'(e_rsp));
        chk({tag, "_latency"}, 128'(rsp_cyc - acc_cyc), 128'(lat));
        step();
        chk({tag, "_rsp_one_cycle"}, 128'(rsp_valid), 128'(0));
        chk({tag, "_ready_after"}, 128'(cmd_ready), 128'(1));
        chk({tag, "_rsp_count"}, 128'(n_rsp), 128'(1));
    endtask

    initial begin
        logic [63:0] d64;
        int k;

        // Reset state
        rstn = 1'b0;
        step(); step(); step();
        chk("rst_tck", 128'(jtag_tck), 128'(0));
        chk("rst_tms", 128'(jtag_tms), 128'(1));
        chk("rst_tdi", 128'(jtag_tdi), 128'(0));
        chk("rst_ready", 128'(cmd_ready), 128'(0));
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_rsp_data", 128'(rsp_data), 128'(0));
        rstn = 1'b1;
        step();
        chk("ready_after_release", 128'(cmd_ready), 128'(1));

        // TAP reset
        tdo_mode = 1; tdo_r = 1'b1;
        do_cmd(2'b00, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "tlr");
        chk("tlr_tms_const", tms_v, 128'h1F);
        chk("tlr_rsp_zero", 128'(rsp_data), 128'(0));

        // DR shift len 8, loopback
        tdo_mode = 0;
        do_cmd(2'b10, 7'd8, 64'hA5, 1'b0, "dr8");
        chk("dr8_tms_const", tms_v, 128'h0C01);
        chk("dr8_tdi_const", tdi_v, 128'h528);
        chk("dr8_rsp_const", 128'(rsp_data), 128'hA5);

        // IR shift len 5, TDO held high
        tdo_mode = 1; tdo_r = 1'b1;
        do_cmd(2'b01, 7'd5, 64'h0E, 1'b0, "ir5");
        chk("ir5_tms_const", tms_v, 128'h303);
        chk("ir5_rsp_const", 128'(rsp_data), 128'h1F);

        // Full-width and clamped DR shifts, loopback
        tdo_mode = 0;
        do_cmd(2'b10, 7'd64, 64'h8000_0000_0000_0001, 1'b0, "dr64");
        chk("dr64_rsp_const", 128'(rsp_data), 128'h8000_0000_0000_0001);
        do_cmd(2'b10, 7'd100, 64'h8000_0000_0000_0001, 1'b0, "dr100");
        chk("dr100_tck_const", 128'(n_rise), 128'(69));
        chk("dr100_rsp_const", 128'(rsp_data), 128'h8000_0000_0000_0001);

        // Idle commands, second one with cmd_valid held while busy
        do_cmd(2'b11, 7'd0, 64'h0, 1'b0, "idle0");
        chk("idle0_no_tck", 128'(n_rise), 128'(0));
        do_cmd(2'b11, 7'd3, 64'h1234, 1'b1, "idle3");
        chk("idle3_tck_const", 128'(n_rise), 128'(3));
        chk("idle3_tms_zero", tms_v, 128'h0);

        // Random commands
        for (int r = 0; r < 24; r++) begin
            tdo_mode = $urandom_range(0, 2);
            tdo_r = (tdo_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            d64 = {$urandom(), $urandom()};
            do_cmd(2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)), d64,
                   bit'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
        end

        // Leave a non-zero response, then reset during bit 4 of a DR shift
        tdo_mode = 0;
        do_cmd(2'b10, 7'd8, 64'hFF, 1'b0, "pre_abort");
        issue(2'b10, 7'd8, 64'h5A, "abort");
        cmd_valid = 1'b0;
        k = 0;
        while (n_rise < 8 && k < 200) begin step(); k++; end
        chk("abort_reached_bit4", 128'(n_rise), 128'(8));
        rstn = 1'b0;
        step();
        chk("abort_tck", 128'(jtag_tck), 128'(0));
        chk("abort_tms", 128'(jtag_tms), 128'(1));
        chk("abort_tdi", 128'(jtag_tdi), 128'(0));
        chk("abort_ready", 128'(cmd_ready), 128'(0));
        chk("abort_rsp_data", 128'(rsp_data), 128'(0));
        step(); step();
        rstn = 1'b1;
        step();
        chk("abort_ready_after_release", 128'(cmd_ready), 128'(1));
        for (int i = 0; i < 40; i++) step();
        chk("abort_no_rsp", 128'(n_rsp), 128'(0));

        // Recovery with a TAP reset
        do_cmd(2'b00, 7'd9, 64'h0, 1'b0, "recover_tlr");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
